// File: rtl/noc_result_writer_pkg.sv
// Shared definitions for the NoC result writer: element/beat geometry and writer FSM states.
package noc_result_writer_pkg;

   localparam int unsigned D_W            = 8;
   localparam int unsigned N1             = 64;
   localparam int unsigned N2             = 64;
   localparam int unsigned AXI_DATA_WIDTH = 128;
   localparam int unsigned BYTES_PER_BEAT = AXI_DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StData,
      StDrain,
      StDone
   } wr_state_e;

   // Number of beats needed to hold n elements of elem_bits each.
   function automatic int unsigned beats_for(input int unsigned n, input int unsigned elem_bits);
      int unsigned per_beat;
      per_beat = AXI_DATA_WIDTH / elem_bits;
      return (n + per_beat - 1) / per_beat;
   endfunction

endpackage

// File: rtl/noc_beat_fifo.sv
// Synchronous FIFO holding completed W beats (data plus strobes) ahead of the AXI write channel.
module noc_beat_fifo #(
   parameter int unsigned WIDTH = 144,
   parameter int unsigned DEPTH = 32
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           push,
   input  logic [WIDTH-1:0]               push_data,
   input  logic                           pop,
   output logic [WIDTH-1:0]               pop_data,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/noc_result_writer.sv
// Packs the GELU element stream into 16-byte beats and writes them to DDR as AXI INCR bursts.
// Optional build macro NOC_WRITER_ALIGN_CHECK_EN rejects starts whose base address is not beat aligned.
module noc_result_writer #(
   parameter int unsigned D_W            = 8,
   parameter int unsigned AXI_DATA_WIDTH = 128,
   parameter int unsigned BURST_LEN      = 16,
   parameter int unsigned MATRIXSIZE_W   = 24
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        start,
   input  logic [63:0]                 base_addr,
   input  logic [MATRIXSIZE_W-1:0]     num_elems,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [D_W-1:0]              s_data,
   output logic                        awvalid,
   input  logic                        awready,
   output logic [63:0]                 awaddr,
   output logic [7:0]                  awlen,
   output logic                        wvalid,
   input  logic                        wready,
   output logic [AXI_DATA_WIDTH-1:0]   wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] wstrb,
   output logic                        wlast,
   input  logic                        bvalid,
   output logic                        bready,
   input  logic [1:0]                  bresp,
   output logic                        busy,
   output logic                        done,
   output logic                        error
);

   import noc_result_writer_pkg::*;

   localparam int unsigned STRB_W      = AXI_DATA_WIDTH / 8;
   localparam int unsigned EPB         = AXI_DATA_WIDTH / D_W;
   localparam int unsigned LANE_W      = $clog2(EPB);
   localparam int unsigned ELEM_STRB   = D_W / 8;
   localparam int unsigned FIFO_DEPTH  = 2 * BURST_LEN;
   localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned FIFO_W      = AXI_DATA_WIDTH + STRB_W;
   localparam int unsigned BLEN_W      = $clog2(BURST_LEN + 1);
   localparam logic [63:0] BURST_BYTES = 64'(BURST_LEN * STRB_W);

   wr_state_e                 state_q;
   logic                      busy_q, done_q, error_q;
   logic [63:0]               addr_q;
   logic [MATRIXSIZE_W-1:0]   beats_left_q;
   logic [BLEN_W-1:0]         burst_len_q, cur_len, w_issued_q;
   logic                      awvalid_q;
   logic [63:0]               awaddr_q;
   logic [7:0]                awlen_q;
   logic                      wvalid_q, wlast_q;
   logic [AXI_DATA_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]         wstrb_q;
   logic [7:0]                outstanding_q;

   logic [MATRIXSIZE_W-1:0]   elems_left_q;
   logic [LANE_W-1:0]         lane_q;
   logic [AXI_DATA_WIDTH-1:0] pack_data_q, merged_data;
   logic [STRB_W-1:0]         pack_strb_q, merged_strb;

   logic                      fifo_full, fifo_empty;
   logic [CNT_W-1:0]          fifo_count;
   logic [FIFO_W-1:0]         fifo_rdata;

   logic                      misaligned, s_hs, beat_push, aw_hs, w_hs, w_load;
   logic [MATRIXSIZE_W:0]     beats_round;
   logic [MATRIXSIZE_W-1:0]   total_beats;

`ifdef NOC_WRITER_ALIGN_CHECK_EN
   assign misaligned = (base_addr[3:0] != 4'h0);
`else
   assign misaligned = 1'b0;
`endif

   assign beats_round = {1'b0, num_elems} + (MATRIXSIZE_W + 1)'(EPB - 1);
   assign total_beats = MATRIXSIZE_W'(beats_round >> LANE_W);
   assign cur_len     = (beats_left_q > MATRIXSIZE_W'(BURST_LEN)) ? BLEN_W'(BURST_LEN)
                                                                   : BLEN_W'(beats_left_q);

   assign s_ready     = busy_q && (elems_left_q != '0) && !fifo_full;
   assign s_hs        = s_valid && s_ready;
   assign merged_data = pack_data_q | (AXI_DATA_WIDTH'(s_data) << (lane_q * D_W));
   assign merged_strb = pack_strb_q | (STRB_W'({ELEM_STRB{1'b1}}) << (lane_q * ELEM_STRB));
   // A beat is complete when its last lane fills or the job's final element arrives.
   assign beat_push   = s_hs && ((lane_q == LANE_W'(EPB - 1)) || (elems_left_q == MATRIXSIZE_W'(1)));

   assign aw_hs  = awvalid_q && awready;
   assign w_hs   = wvalid_q && wready;
   assign w_load = (state_q == StData) && !fifo_empty && (w_issued_q != burst_len_q)
                   && (!wvalid_q || wready);

   noc_beat_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_beat_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (beat_push),
      .push_data ({merged_strb, merged_data}),
      .pop       (w_load),
      .pop_data  (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         elems_left_q <= '0;
         lane_q       <= '0;
         pack_data_q  <= '0;
         pack_strb_q  <= '0;
      end else if (start && (state_q == StIdle)) begin
         elems_left_q <= misaligned ? '0 : num_elems;
         lane_q       <= '0;
         pack_data_q  <= '0;
         pack_strb_q  <= '0;
      end else if (s_hs) begin
         elems_left_q <= elems_left_q - 1'b1;
         if (beat_push) begin
            lane_q      <= '0;
            pack_data_q <= '0;
            pack_strb_q <= '0;
         end else begin
            lane_q      <= lane_q + 1'b1;
            pack_data_q <= merged_data;
            pack_strb_q <= merged_strb;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= StIdle;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         addr_q       <= '0;
         beats_left_q <= '0;
         burst_len_q  <= '0;
         awvalid_q    <= 1'b0;
         awaddr_q     <= '0;
         awlen_q      <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  busy_q       <= 1'b1;
                  error_q      <= misaligned;
                  addr_q       <= base_addr;
                  beats_left_q <= total_beats;
                  if (misaligned || (num_elems == '0)) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StAddr;
                  end
               end
            end
            StAddr: begin
               if (aw_hs) begin
                  awvalid_q    <= 1'b0;
                  state_q      <= StData;
                  beats_left_q <= beats_left_q - MATRIXSIZE_W'(burst_len_q);
                  addr_q       <= addr_q + BURST_BYTES;
               end else if (!awvalid_q && (32'(fifo_count) >= 32'(cur_len))) begin
                  // The whole burst is buffered, so W can never starve mid-burst.
                  awvalid_q   <= 1'b1;
                  awaddr_q    <= addr_q;
                  awlen_q     <= 8'(cur_len - 1'b1);
                  burst_len_q <= cur_len;
               end
            end
            StData: begin
               if (w_hs && wlast_q) state_q <= (beats_left_q != '0) ? StAddr : StDrain;
            end
            StDrain: begin
               if (outstanding_q == '0) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
         if (bvalid && (bresp != 2'b00)) error_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wvalid_q   <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         wlast_q    <= 1'b0;
         w_issued_q <= '0;
      end else if (aw_hs) begin
         w_issued_q <= '0;
      end else if (w_load) begin
         wvalid_q   <= 1'b1;
         wdata_q    <= fifo_rdata[AXI_DATA_WIDTH-1:0];
         wstrb_q    <= fifo_rdata[FIFO_W-1:AXI_DATA_WIDTH];
         wlast_q    <= (w_issued_q == burst_len_q - 1'b1);
         w_issued_q <= w_issued_q + 1'b1;
      end else if (w_hs) begin
         wvalid_q <= 1'b0;
         wlast_q  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         outstanding_q <= '0;
      end else if (aw_hs && !bvalid) begin
         outstanding_q <= outstanding_q + 8'd1;
      end else if (!aw_hs && bvalid && (outstanding_q != '0)) begin
         outstanding_q <= outstanding_q - 8'd1;
      end
   end

   assign awvalid = awvalid_q;
   assign awaddr  = awaddr_q;
   assign awlen   = awlen_q;
   assign wvalid  = wvalid_q;
   assign wdata   = wdata_q;
   assign wstrb   = wstrb_q;
   assign wlast   = wlast_q;
   assign bready  = 1'b1;
   assign busy    = busy_q;
   assign done    = done_q;
   assign error   = error_q;

endmodule
